// File: rtl/evg_event_arbiter.sv
// Event-code arbiter: per-requester FIFOs feeding a single registered output slot.
// Define EVG_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority, index 0 highest).
//
// state   | meaning
// IDLE    | output slot empty, evgEventTVALID low
// HOLD    | output slot holds a granted code, evgEventTVALID high
module evg_event_arbiter #(
    parameter int NUM_REQUESTERS  = 4,
    parameter int EVENTCODE_WIDTH = 8,
    parameter int FIFO_ADDR_WIDTH = 2
) (
    input  logic                                      evgTxClk,
    input  logic                                      evgTxRst_n,
    input  logic [NUM_REQUESTERS*EVENTCODE_WIDTH-1:0] reqTDATA,
    input  logic [NUM_REQUESTERS-1:0]                 reqTVALID,
    output logic [EVENTCODE_WIDTH-1:0]                evgEventTDATA,
    output logic                                      evgEventTVALID,
    input  logic                                      evgEventTREADY,
    output logic [NUM_REQUESTERS-1:0]                 overflowFlags,
    input  logic [NUM_REQUESTERS-1:0]                 overflowClear,
    output logic [NUM_REQUESTERS*8-1:0]               dropCounts,
    output logic [NUM_REQUESTERS-1:0]                 fifoEmpty
);

    localparam int N     = NUM_REQUESTERS;
    localparam int W     = EVENTCODE_WIDTH;
    localparam int A     = FIFO_ADDR_WIDTH;
    localparam int DEPTH = 1 << A;
    localparam int IDXW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [A:0] PTR_ONE = 1;

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    data_q, data_d;
    logic [W-1:0]    mem_q [N][DEPTH];
    logic [W-1:0]    mem_d [N][DEPTH];
    logic [A:0]      wptr_q [N];
    logic [A:0]      wptr_d [N];
    logic [A:0]      rptr_q [N];
    logic [A:0]      rptr_d [N];
    logic [7:0]      cnt_q [N];
    logic [7:0]      cnt_d [N];
    logic [N-1:0]    empty_q, empty_d;
    logic [N-1:0]    flag_q, flag_d;
    logic [N-1:0]    not_empty, full, push, drop;
    logic            any_req, load;
    logic [IDXW-1:0] grant_idx;

    // Full is taken from the registered pointers, so a same-cycle pop never rescues a write.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            not_empty[i] = (wptr_q[i] != rptr_q[i]);
            full[i]      = (wptr_q[i][A] != rptr_q[i][A]) &&
                           (wptr_q[i][A-1:0] == rptr_q[i][A-1:0]);
            push[i]      = reqTVALID[i] && (reqTDATA[i*W +: W] != '0) && !full[i];
            drop[i]      = reqTVALID[i] && (reqTDATA[i*W +: W] != '0) && full[i];
        end
    end

`ifdef EVG_ARB_ROUND_ROBIN_EN
    logic [IDXW-1:0] rr_q, rr_d;
    int              rr_idx;

    always_comb begin
        grant_idx = '0;
        any_req   = 1'b0;
        rr_idx    = 0;
        for (int k = 0; k < N; k++) begin
            rr_idx = (int'(rr_q) + 1 + k) % N;
            if (!any_req && not_empty[IDXW'(rr_idx)]) begin
                any_req   = 1'b1;
                grant_idx = IDXW'(rr_idx);
            end
        end
        rr_d = (load && any_req) ? grant_idx : rr_q;
    end

    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n) rr_q <= IDXW'(N - 1);
        else             rr_q <= rr_d;
    end
`else
    always_comb begin
        grant_idx = '0;
        any_req   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (not_empty[k]) begin
                any_req   = 1'b1;
                grant_idx = IDXW'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mem_d   = mem_q;
        flag_d  = flag_q;
        empty_d = empty_q;
        for (int i = 0; i < N; i++) begin
            wptr_d[i] = wptr_q[i];
            rptr_d[i] = rptr_q[i];
            cnt_d[i]  = cnt_q[i];
        end

        load = (state_q == ST_IDLE) || evgEventTREADY;
        if (load) begin
            if (any_req) begin
                state_d = ST_HOLD;
                data_d  = mem_q[grant_idx][rptr_q[grant_idx][A-1:0]];
            end else begin
                state_d = ST_IDLE;
            end
        end

        for (int i = 0; i < N; i++) begin
            if (load && any_req && (grant_idx == IDXW'(i)))
                rptr_d[i] = rptr_q[i] + PTR_ONE;
            if (push[i]) begin
                mem_d[i][wptr_q[i][A-1:0]] = reqTDATA[i*W +: W];
                wptr_d[i] = wptr_q[i] + PTR_ONE;
            end
            if (overflowClear[i]) begin
                flag_d[i] = 1'b0;
                cnt_d[i]  = 8'd0;
            end
            // A drop in the same cycle as a clear leaves exactly that one drop recorded.
            if (drop[i]) begin
                flag_d[i] = 1'b1;
                if (overflowClear[i])        cnt_d[i] = 8'd1;
                else if (cnt_q[i] != 8'hFF)  cnt_d[i] = cnt_q[i] + 8'd1;
            end
            empty_d[i] = (wptr_d[i] == rptr_d[i]);
        end
    end

    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            empty_q <= '1;
            flag_q  <= '0;
            for (int i = 0; i < N; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
                for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
            end
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            empty_q <= empty_d;
            flag_q  <= flag_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) dropCounts[i*8 +: 8] = cnt_q[i];
    end

    assign evgEventTDATA  = data_q;
    assign evgEventTVALID = (state_q == ST_HOLD);
    assign overflowFlags  = flag_q;
    assign fifoEmpty      = empty_q;

endmodule

// File: tb/tb_evg_event_arbiter.sv
// Scoreboard bench for evg_event_arbiter: stimulus queues expected codes, a negedge monitor checks accepted outputs.
module tb_evg_event_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] req_tdata;
    logic [3:0]  req_tvalid;
    logic [7:0]  ev_tdata;
    logic        ev_tvalid;
    logic        ev_tready;
    logic [3:0]  ovf_flags;
    logic [3:0]  ovf_clear;
    logic [31:0] drop_counts;
    logic [3:0]  fifo_empty;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q [$];

    evg_event_arbiter #(
        .NUM_REQUESTERS (4),
        .EVENTCODE_WIDTH(8),
        .FIFO_ADDR_WIDTH(2)
    ) dut (
        .evgTxClk      (clk),
        .evgTxRst_n    (rst_n),
        .reqTDATA      (req_tdata),
        .reqTVALID     (req_tvalid),
        .evgEventTDATA (ev_tdata),
        .evgEventTVALID(ev_tvalid),
        .evgEventTREADY(ev_tready),
        .overflowFlags (ovf_flags),
        .overflowClear (ovf_clear),
        .dropCounts    (drop_counts),
        .fifoEmpty     (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ev_tvalid && ev_tready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got 0x%0h expected none at %0t", ev_tdata, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (ev_tdata !== e) begin
                    n_err++;
                    $display("FAIL event_code: got 0x%0h expected 0x%0h at %0t", ev_tdata, e, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int idx, input logic [7:0] code);
        req_tvalid = '0;
        req_tvalid[idx] = 1'b1;
        req_tdata[idx*8 +: 8] = code;
        tick();
        req_tvalid = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        req_tdata  = '0;
        req_tvalid = '0;
        ev_tready  = 1'b1;
        ovf_clear  = '0;
        do_reset();

        check("rst_tvalid", {31'd0, ev_tvalid}, 32'd0);
        check("rst_tdata", {24'd0, ev_tdata}, 32'd0);
        check("rst_flags", {28'd0, ovf_flags}, 32'd0);
        check("rst_drops", drop_counts, 32'd0);
        check("rst_empty", {28'd0, fifo_empty}, 32'hF);

        // single request, two-cycle latency, one-cycle valid
        exp_q.push_back(8'h14);
        req(2, 8'h14);
        check("single_empty_c1", {28'd0, fifo_empty}, 32'hB);
        check("single_tvalid_c1", {31'd0, ev_tvalid}, 32'd0);
        tick();
        check("single_tvalid_c2", {31'd0, ev_tvalid}, 32'd1);
        check("single_tdata_c2", {24'd0, ev_tdata}, 32'h14);
        tick();
        check("single_tvalid_c3", {31'd0, ev_tvalid}, 32'd0);
        check("single_empty_c3", {28'd0, fifo_empty}, 32'hF);

        // simultaneous requests drain in index order at full rate
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h11 * (i + 1));
        req_tdata  = 32'h44332211;
        req_tvalid = 4'hF;
        tick();
        req_tvalid = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("simul_tvalid", {31'd0, ev_tvalid}, 32'd1);
            check("simul_tdata", {24'd0, ev_tdata}, 32'h11 * (k + 1));
        end
        tick();
        check("simul_idle", {31'd0, ev_tvalid}, 32'd0);
        repeat (3) tick();

        // backpressure holds the slot stable
        ev_tready = 1'b0;
        exp_q.push_back(8'h05);
        req(0, 8'h05);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_hold", {23'd0, ev_tvalid, ev_tdata}, {23'd0, 1'b1, 8'h05});
        end
        ev_tready = 1'b1;
        tick();
        check("bp_released", {31'd0, ev_tvalid}, 32'd0);

        // overflow on requester 1
        ev_tready = 1'b0;
        for (int k = 0; k < 5; k++) exp_q.push_back(8'h30 + 8'(k));
        for (int k = 0; k < 6; k++) begin
            req_tvalid = 4'b0010;
            req_tdata[15:8] = 8'h30 + 8'(k);
            tick();
        end
        req_tvalid = '0;
        check("ovf_flags", {28'd0, ovf_flags}, 32'h2);
        check("ovf_count1", {24'd0, drop_counts[15:8]}, 32'd1);
        check("ovf_out_reg", {23'd0, ev_tvalid, ev_tdata}, {23'd0, 1'b1, 8'h30});
        ovf_clear = 4'b0010;
        tick();
        ovf_clear = '0;
        check("ovf_clr_flags", {28'd0, ovf_flags}, 32'h0);
        check("ovf_clr_count", drop_counts, 32'd0);
        ev_tready = 1'b1;
        repeat (8) tick();

        // null events are discarded silently
        req_tdata  = '0;
        req_tvalid = 4'hF;
        tick();
        req_tvalid = '0;
        check("null_empty", {28'd0, fifo_empty}, 32'hF);
        tick();
        check("null_tvalid", {31'd0, ev_tvalid}, 32'd0);
        check("null_drops", drop_counts, 32'd0);
        check("null_flags", {28'd0, ovf_flags}, 32'd0);

        // saturation after 300 drops, then clear coinciding with a drop
        ev_tready = 1'b0;
        for (int k = 0; k < 5; k++) exp_q.push_back(8'h77);
        req_tdata[31:24] = 8'h77;
        req_tvalid = 4'b1000;
        for (int k = 0; k < 305; k++) tick();
        check("sat_count3", {24'd0, drop_counts[31:24]}, 32'd255);
        check("sat_flags", {28'd0, ovf_flags}, 32'h8);
        ovf_clear = 4'b1000;
        tick();
        ovf_clear  = '0;
        req_tvalid = '0;
        check("setwins_count3", {24'd0, drop_counts[31:24]}, 32'd1);
        check("setwins_flags", {28'd0, ovf_flags}, 32'h8);
        ovf_clear = 4'b1000;
        tick();
        ovf_clear = '0;
        ev_tready = 1'b1;
        repeat (8) tick();

        // reset mid-flight discards queued and held events
        ev_tready = 1'b0;
        req(0, 8'h09);
        req(1, 8'h0A);
        check("inflight_empty", {28'd0, fifo_empty}, 32'hD);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tvalid", {31'd0, ev_tvalid}, 32'd0);
        check("async_rst_empty", {28'd0, fifo_empty}, 32'hF);
        exp_q.delete();
        tick();
        rst_n     = 1'b1;
        ev_tready = 1'b1;
        repeat (4) tick();

        // fairness: requesters 0 and 1 refilled every cycle
        do_reset();
`ifdef EVG_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(8'h01 + 8'(k));
            exp_q.push_back(8'h81 + 8'(k));
        end
`else
        for (int k = 0; k < 6; k++) exp_q.push_back(8'h01 + 8'(k));
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h81 + 8'(k));
`endif
        for (int k = 0; k < 6; k++) begin
            req_tvalid = 4'b0011;
            req_tdata[7:0]  = 8'h01 + 8'(k);
            req_tdata[15:8] = 8'h81 + 8'(k);
            tick();
        end
        req_tvalid = '0;
        repeat (16) tick();
`ifdef EVG_ARB_ROUND_ROBIN_EN
        check("fair_drops1", {24'd0, drop_counts[15:8]}, 32'd0);
`else
        check("fair_drops1", {24'd0, drop_counts[15:8]}, 32'd2);
`endif

        check("drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
